// File: rtl/fib_seq_engine.sv
// rtl/fib_seq_engine.sv - iterative Fibonacci / user-seeded sequence term engine
module fib_seq_engine #(
    parameter int WIDTH = 16,
    parameter int NW    = 5
) (
    input  logic             clk,
    input  logic             usr_reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [NW-1:0]    n_in,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [NW-1:0]    n_reg;
    logic [WIDTH-1:0] cur, nxt;
    logic             cur_tag, nxt_tag;
    logic [WIDTH:0]   sum;
    logic             at_end;

    assign sum    = {1'b0, cur} + {1'b0, nxt};
    assign at_end = (count == n_reg);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge usr_reset) begin
        if (!usr_reset) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (abort)       state_next = IDLE;
                else if (at_end) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tags track whether the true (untruncated) value of each held term has
    // exceeded WIDTH bits; only the tag of the returned term is reported.
    always_ff @(posedge clk or negedge usr_reset) begin
        if (!usr_reset) begin
            n_reg    <= '0;
            cur      <= '0;
            nxt      <= '0;
            cur_tag  <= 1'b0;
            nxt_tag  <= 1'b0;
            count    <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg   <= n_in;
                        cur     <= mode ? seed0 : '0;
                        nxt     <= mode ? seed1 : WIDTH'(1);
                        count   <= '0;
                        cur_tag <= 1'b0;
                        nxt_tag <= 1'b0;
                    end
                end
                RUN: begin
                    if (!abort) begin
                        if (at_end) begin
                            result   <= cur;
                            overflow <= cur_tag;
                        end else begin
                            cur     <= nxt;
                            nxt     <= sum[WIDTH-1:0];
                            count   <= count + NW'(1);
                            cur_tag <= nxt_tag;
                            nxt_tag <= cur_tag | nxt_tag | sum[WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fib_seq_engine.md
FIB_SEQ_ENGINE -- requirements
Module: fib_seq_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the bit width of sequence values, seeds and result.
REQ-002 The block SHALL have parameter NW, default 5, meaning the bit width of the requested index and the step counter.
REQ-003 The block SHALL have port clk, input, 1, meaning the single rising-edge clock for all state.
REQ-004 The block SHALL have port usr_reset, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, meaning a request to compute term n_in.
REQ-006 The block SHALL have port abort, input, 1, meaning cancel the computation in progress.
REQ-007 The block SHALL have port mode, input, 1, meaning seed select: 0 = Fibonacci (0,1), 1 = user seeds.
REQ-008 The block SHALL have port n_in, input, NW, meaning the requested term index.
REQ-009 The block SHALL have port seed0, input, WIDTH, meaning the user term F(0), used when mode=1.
REQ-010 The block SHALL have port seed1, input, WIDTH, meaning the user term F(1), used when mode=1.
REQ-011 The block SHALL have port result, output, WIDTH, meaning the last completed F(n).
REQ-012 The block SHALL have port overflow, output, 1, meaning the true F(n) exceeded 2^WIDTH-1 in the last completed run.
REQ-013 The block SHALL have port busy, output, 1, meaning the block is not in IDLE.
REQ-014 The block SHALL have port done, output, 1, meaning a one-cycle completion pulse.
REQ-015 The block SHALL have port count, output, NW, meaning the current step index.

Function
REQ-016 The block SHALL define the sequence as F(k) = F(k-1) + F(k-2) mod 2^WIDTH, with F(0)/F(1) = 0/1 (mode=0) or seed0/seed1 (mode=1).
REQ-017 The block SHALL implement FSM states IDLE, RUN and DONE, and busy SHALL be 1 in RUN and DONE.
REQ-018 In IDLE, start=1 at an edge SHALL capture n_in into n_reg, load cur=F(0), nxt=F(1) and count=0, clear both per-term overflow tags, and enter RUN; mode and seeds SHALL be sampled only at this edge.
REQ-019 In RUN, if count==n_reg, the block SHALL load result=cur and overflow=cur's tag, and enter DONE.
REQ-020 In RUN, otherwise, the block SHALL set cur=nxt, nxt=cur+nxt (truncated to WIDTH), and count=count+1.
REQ-021 The overflow tag of the new nxt SHALL be cur_tag OR nxt_tag OR the adder carry-out, and cur_tag SHALL take the old nxt_tag; overflow caused only by F(n+1) SHALL NOT be reported.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-023 Latency SHALL be: start accepted at edge E0; done high during the cycle after edge E(n_reg+1); total n_reg+2 cycles from E0 to IDLE.
REQ-024 start SHALL be ignored while busy=1, including during DONE.
REQ-025 abort=1 in RUN SHALL return the block to IDLE at the next edge with result, overflow unchanged and no done pulse; abort SHALL be ignored in IDLE and DONE; abort has priority over completion in the same cycle.
REQ-026 abort=1 together with start=1 in IDLE SHALL start a run, since abort is ignored in IDLE.
REQ-027 result and overflow SHALL hold their values until the next completed run.
REQ-028 n_in=0 SHALL complete with result=F(0) after 2 cycles; n_in=2^NW-1 SHALL complete without counter wrap.
REQ-029 count SHALL reflect the step register in RUN and hold its final value in DONE and IDLE until the next start.

Reset
REQ-030 usr_reset=0 SHALL asynchronously force state=IDLE and clear result, overflow, count, done, busy, n_reg, cur, nxt and the overflow tags to 0, including mid-run.
REQ-031 After reset release, the first start SHALL behave per REQ-018 with no residue from the interrupted run.

Verification
REQ-032 Scenario: WIDTH=16, mode=0, n_in=10, start pulse -> done high 12 cycles after the start edge, result=55, overflow=0, count=10.
REQ-033 Scenario: mode=0, n_in=0 -> result=0, done 2 cycles after start; then n_in=1 -> result=1, done after 3 cycles.
REQ-034 Scenario: WIDTH=16, mode=0, n_in=24 -> result=46368, overflow=0 (F(25) overflows internally but is not reported); then n_in=25 -> result=9489, overflow=1.
REQ-035 Scenario: mode=1, seed0=2, seed1=1, n_in=5 -> result=11 (Lucas); seeds changed mid-run do not alter the result.
REQ-036 Scenario: n_in=20 run, abort at count=7 -> busy drops next cycle, no done, result/overflow keep the prior values; a start asserted mid-run is ignored.
REQ-037 Scenario: usr_reset pulled low mid-run at count=5 -> all outputs 0 immediately, state IDLE; after release, n_in=6 -> result=8.
